// File: rtl/ball_bounce.sv
// Autonomous Pong ball engine.
// Steps a quarter-pixel ball position once per frame, bounces it off the top
// and bottom walls and the two paddles, emits a one-clock score pulse when a
// paddle misses, freezes the ball for a hold-off period, then recentres it and
// waits for the next serve. The renderer uses x_out[12:2] / y_out[12:2].
module ball_bounce #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 20,
    parameter int PADDLE_H    = 80,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_X_L  = 16,
    parameter int PADDLE_X_R  = 616,
    parameter int SPEED       = 8,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               serve,
    input  logic               serve_dir,
    input  logic [9:0]         paddle_l_y,
    input  logic [9:0]         paddle_r_y,
    output logic signed [12:0] x_out,
    output logic signed [12:0] y_out,
    output logic               moving,
    output logic               score_l,
    output logic               score_r
);

    // Positions are in quarter-pixels, so every pixel geometry is scaled by 4.
    localparam logic signed [12:0] X_CENTER = 13'((SCREEN_W - BALL_SIZE) / 2 * 4);
    localparam logic signed [12:0] Y_CENTER = 13'((SCREEN_H - BALL_SIZE) / 2 * 4);
    localparam logic signed [12:0] Y_MIN    = 13'sd0;
    localparam logic signed [12:0] Y_MAX    = 13'((SCREEN_H - BALL_SIZE) * 4);
    localparam logic signed [12:0] X_LIM_L  = 13'((PADDLE_X_L + PADDLE_W) * 4);
    localparam logic signed [12:0] X_LIM_R  = 13'((PADDLE_X_R - BALL_SIZE) * 4);
    localparam logic signed [12:0] STEP     = 13'(SPEED);

    // Overlap spans in pixel rows (inclusive far edge).
    localparam logic [11:0] BALL_SPAN   = 12'(BALL_SIZE - 1);
    localparam logic [11:0] PADDLE_SPAN = 12'(PADDLE_H - 1);

    localparam int          HOLD_W    = $clog2(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    // Direction flags: dir_x 1 = right, dir_y 1 = down.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]        state;
    logic              dir_x;
    logic              dir_y;
    logic [HOLD_W-1:0] hold_cnt;

    logic signed [12:0] nx;
    logic signed [12:0] ny;
    logic signed [12:0] x_next;
    logic signed [12:0] y_next;
    logic               dir_x_next;
    logic               dir_y_next;
    logic [11:0]        y_row;
    logic               miss_l;
    logic               miss_r;

    // True when a ball whose top pixel row is `row` overlaps a paddle at `top`.
    function automatic logic paddle_overlap(input logic [11:0] row,
                                            input logic [9:0]  top);
        logic [11:0] top_ext;
        top_ext = {2'b00, top};
        return ((row + BALL_SPAN) >= top_ext) && (row <= (top_ext + PADDLE_SPAN));
    endfunction

    // Candidate next position and directions for a MOVE-state frame step.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        nx         = dir_x ? (x_out + STEP) : (x_out - STEP);
        ny         = dir_y ? (y_out + STEP) : (y_out - STEP);
        y_next     = ny;
        dir_y_next = dir_y;
        x_next     = nx;
        dir_x_next = dir_x;
        miss_l     = 1'b0;
        miss_r     = 1'b0;

        if (ny <= Y_MIN) begin
            y_next     = Y_MIN;
            dir_y_next = 1'b1;
        end else if (ny >= Y_MAX) begin
            y_next     = Y_MAX;
            dir_y_next = 1'b0;
        end

        // The paddle test uses the row the ball is about to occupy.
        y_row = {1'b0, y_next[12:2]};

        if (!dir_x && (nx <= X_LIM_L)) begin
            x_next = X_LIM_L;
            if (paddle_overlap(y_row, paddle_l_y)) begin
                dir_x_next = 1'b1;
            end else begin
                miss_l = 1'b1;
            end
        end else if (dir_x && (nx >= X_LIM_R)) begin
            x_next = X_LIM_R;
            if (paddle_overlap(y_row, paddle_r_y)) begin
                dir_x_next = 1'b0;
            end else begin
                miss_r = 1'b1;
            end
        end
    end

    // Serve / move / hold-off state machine with the position registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            x_out    <= X_CENTER;
            y_out    <= Y_CENTER;
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            hold_cnt <= '0;
            score_l  <= 1'b0;
            score_r  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            score_l <= 1'b0;
            score_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (serve) begin
                        state <= ST_MOVE;
                        dir_x <= serve_dir;
                    end
                end
                ST_MOVE: begin
                    if (frame_tick) begin
                        x_out <= x_next;
                        y_out <= y_next;
                        dir_x <= dir_x_next;
                        dir_y <= dir_y_next;
                        if (miss_l || miss_r) begin
                            state    <= ST_HOLD;
                            hold_cnt <= '0;
                            score_r  <= miss_l;
                            score_l  <= miss_r;
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= ST_IDLE;
                            x_out    <= X_CENTER;
                            y_out    <= Y_CENTER;
                            dir_x    <= ~dir_x;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign moving = (state == ST_MOVE);

endmodule

// File: tb/tb_ball_bounce.sv
// Self-checking bench for ball_bounce: a vector table for the serve/step
// basics, hand-written sequences for bounces, misses, hold-off and reset,
// then randomized play compared against a frame-level reference model.
module tb_ball_bounce;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_tick;
    logic               serve;
    logic               serve_dir;
    logic [9:0]         paddle_l_y;
    logic [9:0]         paddle_r_y;
    logic signed [12:0] x_out;
    logic signed [12:0] y_out;
    logic               moving;
    logic               score_l;
    logic               score_r;

    int checks = 0;
    int errors = 0;

    // Reference model state, in plain integers.
    int m_x;
    int m_y;
    bit m_right;
    bit m_down;
    bit m_play;
    int m_frozen;   // frames still to wait before recentring (0 = not frozen)
    bit m_sl;
    bit m_sr;

    typedef struct {
        int reps;
        bit tick;
        bit srv;
        bit sdir;
        int ex;
        int ey;
        bit emov;
        bit esl;
        bit esr;
    } vec_t;

    vec_t tbl[7];

    ball_bounce dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .x_out      (x_out),
        .y_out      (y_out),
        .moving     (moving),
        .score_l    (score_l),
        .score_r    (score_r)
    );

    always #10 clk = ~clk;

    initial begin
        #(20 * 100000);
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [31:0] actual,
                         input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_x = 1240; m_y = 920; m_right = 1'b1; m_down = 1'b1;
        m_play = 1'b0; m_frozen = 0; m_sl = 1'b0; m_sr = 1'b0;
    endtask

    // One clock of the reference model, applied with the inputs seen at the edge.
    task automatic model_cycle(input bit tick, input bit srv, input bit sdir,
                               input int pl, input int pr);
        int nx;
        int ny;
        int row;
        m_sl = 1'b0;
        m_sr = 1'b0;
        if (m_frozen > 0) begin
            if (tick) begin
                m_frozen--;
                if (m_frozen == 0) begin
                    m_x = 1240; m_y = 920; m_right = !m_right;
                end
            end
        end else if (!m_play) begin
            if (srv) begin
                m_play  = 1'b1;
                m_right = sdir;
            end
        end else if (tick) begin
            nx = m_right ? m_x + 8 : m_x - 8;
            ny = m_down ? m_y + 8 : m_y - 8;
            if (ny <= 0) begin
                ny = 0; m_down = 1'b1;
            end else if (ny >= 1840) begin
                ny = 1840; m_down = 1'b0;
            end
            row = ny / 4;
            if (!m_right && nx <= 96) begin
                nx = 96;
                if (row + 19 >= pl && row <= pl + 79) m_right = 1'b1;
                else begin m_play = 1'b0; m_frozen = 60; m_sr = 1'b1; end
            end else if (m_right && nx >= 2384) begin
                nx = 2384;
                if (row + 19 >= pr && row <= pr + 79) m_right = 1'b0;
                else begin m_play = 1'b0; m_frozen = 60; m_sl = 1'b1; end
            end
            m_x = nx;
            m_y = ny;
        end
    endtask

    // Drive one clock of inputs, update the model at the edge, sample after it.
    task automatic cycle(input bit tick, input bit srv, input bit sdir,
                         input int pl, input int pr);
        @(negedge clk);
        frame_tick = tick;
        serve      = srv;
        serve_dir  = sdir;
        paddle_l_y = 10'(pl);
        paddle_r_y = 10'(pr);
        @(posedge clk);
        model_cycle(tick, srv, sdir, pl, pr);
        #1;
        frame_tick = 1'b0;
        serve      = 1'b0;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, "_x"},  x_out,   m_x);
        check({tag, "_y"},  y_out,   m_y);
        check({tag, "_mv"}, moving,  int'(m_play));
        check({tag, "_sl"}, score_l, int'(m_sl));
        check({tag, "_sr"}, score_r, int'(m_sr));
    endtask

    // Reset asserted between clock edges must take effect immediately.
    task automatic pulse_reset();
        @(negedge clk);
        #5 rst = 1'b0;
        #1;
        check("rst_x",  x_out,   1240);
        check("rst_y",  y_out,   920);
        check("rst_mv", moving,  0);
        check("rst_sl", score_l, 0);
        check("rst_sr", score_r, 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Paddle top placed so the ball's rows sit inside it, offset by `off` rows.
    function automatic int track(input int y_q, input int off);
        int p;
        p = y_q / 4 - off;
        if (p < 0) p = 0;
        if (p > 1023) p = 1023;
        return p;
    endfunction

    initial begin
        int err_before;
        int pl;
        int pr;

        rst = 1'b0; frame_tick = 1'b0; serve = 1'b0; serve_dir = 1'b0;
        paddle_l_y = 10'd200; paddle_r_y = 10'd200;
        model_reset();
        #35;
        check("init_x",  x_out,   1240);
        check("init_y",  y_out,   920);
        check("init_mv", moving,  0);
        check("init_sl", score_l, 0);
        rst = 1'b1;

        // ---- Table: idle ticks, serve, stepping, serve ignored while moving.
        tbl[0] = '{10, 1'b1, 1'b0, 1'b0, 1240, 920, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1,  1'b0, 1'b1, 1'b1, 1240, 920, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1,  1'b1, 1'b0, 1'b0, 1248, 928, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1,  1'b0, 1'b0, 1'b0, 1248, 928, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{2,  1'b1, 1'b0, 1'b0, 1264, 944, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1,  1'b0, 1'b1, 1'b0, 1264, 944, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1,  1'b1, 1'b0, 1'b0, 1272, 952, 1'b1, 1'b0, 1'b0};
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < tbl[r].reps; k++)
                cycle(tbl[r].tick, tbl[r].srv, tbl[r].sdir, 200, 200);
            check($sformatf("tbl%0d_x", r),  x_out,   tbl[r].ex);
            check($sformatf("tbl%0d_y", r),  y_out,   tbl[r].ey);
            check($sformatf("tbl%0d_mv", r), moving,  int'(tbl[r].emov));
            check($sformatf("tbl%0d_sl", r), score_l, int'(tbl[r].esl));
            check($sformatf("tbl%0d_sr", r), score_r, int'(tbl[r].esr));
        end

        // ---- One-clock latency: no change before the edge that samples the tick.
        @(negedge clk);
        frame_tick = 1'b1;
        #1 check("lat_before", x_out, 1272);
        @(posedge clk);
        #1 check("lat_after", x_out, 1280);
        frame_tick = 1'b0;

        // ---- Reset mid-MOVE, then play with tracking paddles to the top wall.
        pulse_reset();
        cycle(1'b0, 1'b1, 1'b1, 200, 200);
        for (int i = 1; i <= 346; i++) begin
            cycle(1'b1, 1'b0, 1'b0, track(m_y, 30), track(m_y, 30));
            if (i == 115) check("bot_clamp_y", y_out, 1840);
            if (i == 143) check("rhit_x", x_out, 2384);
            if (i == 345) check("top_clamp_y", y_out, 0);
            if (i == 346) check("top_bounce_y", y_out, 8);
        end
        cmp_model("rally");

        // ---- Left paddle hit.
        pulse_reset();
        cycle(1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 143; i++) cycle(1'b1, 1'b0, 1'b0, track(m_y, 30), 0);
        check("lhit_x",  x_out,   96);
        check("lhit_sr", score_r, 0);
        check("lhit_mv", moving,  1);
        cycle(1'b1, 1'b0, 1'b0, track(m_y, 30), 0);
        check("lhit_back_x", x_out, 104);

        // ---- Left paddle miss, hold-off (serve ignored), recentre, reserve.
        pulse_reset();
        cycle(1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 142; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);
        check("pre_miss_x", x_out, 104);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        check("miss_x",  x_out,   96);
        check("miss_y",  y_out,   1616);
        check("miss_sr", score_r, 1);
        check("miss_sl", score_l, 0);
        check("miss_mv", moving,  0);
        cycle(1'b0, 1'b0, 1'b0, 0, 0);
        check("miss_sr_end", score_r, 0);
        for (int i = 1; i <= 59; i++) cycle(1'b1, (i % 10) == 0, 1'b1, 0, 0);
        check("hold_x",  x_out,  96);
        check("hold_mv", moving, 0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        check("recentre_x",  x_out,  1240);
        check("recentre_y",  y_out,  920);
        check("recentre_mv", moving, 0);
        cycle(1'b0, 1'b1, 1'b1, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        check("reserve_x", x_out, 1248);
        cmp_model("reserve");

        // ---- Reset during HOLD, then serve coincident with a tick takes no step.
        pulse_reset();
        cycle(1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 148; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);
        check("hold2_mv", moving, 0);
        pulse_reset();
        cycle(1'b1, 1'b1, 1'b1, 0, 0);
        check("srv_tick_x",  x_out,  1240);
        check("srv_tick_y",  y_out,  920);
        check("srv_tick_mv", moving, 1);
        cycle(1'b1, 1'b0, 1'b0, 0, 0);
        check("srv_step_x", x_out, 1248);
        check("srv_step_y", y_out, 928);

        // ---- Randomized play against the reference model.
        pulse_reset();
        err_before = errors;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                pl = track(m_y, int'($urandom_range(0, 110)) - 20);
                pr = track(m_y, int'($urandom_range(0, 110)) - 20);
            end else begin
                pl = int'($urandom_range(0, 400));
                pr = int'($urandom_range(0, 400));
            end
            if ($urandom_range(0, 1999) == 0) pulse_reset();
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                  1'($urandom_range(0, 1)), pl, pr);
            cmp_model("rand");
            if (errors != err_before) break;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
